// File: rtl/lfsr_rand_ranged.sv
// lfsr_rand_ranged: Galois LFSR random source whose draws are reduced modulo a runtime range (restoring divider) and offset by a base.
module lfsr_rand_ranged #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hA011,
  parameter logic [WIDTH-1:0] SEED  = 16'h006F,
  parameter int               OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             free_run,
  input  logic             req,
  input  logic [OUT_W-1:0] range,
  input  logic [OUT_W-1:0] base,
  output logic             rdy,
  output logic             rnd_valid,
  output logic [OUT_W-1:0] rnd_out,
  output logic [WIDTH-1:0] lfsr_q
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t           st;
  logic [WIDTH-1:0] lfsr, nxt, dividend;
  logic [OUT_W:0]   rem, rem_nxt;
  logic [OUT_W+1:0] r;
  logic [OUT_W-1:0] rng, base_q;
  logic [CW-1:0]    cnt;
  assign rdy    = st == IDLE;
  assign lfsr_q = lfsr;
  // an all-zero state would lock the LFSR, so it falls back to SEED instead
  always_comb begin
    nxt     = (lfsr == '0) ? SEED : ({lfsr[WIDTH-2:0], 1'b0} ^ (lfsr[WIDTH-1] ? TAPS : '0));
    r       = {rem, dividend[cnt]};
    rem_nxt = (rng == '0) ? (OUT_W+1)'(dividend) :
              (r >= {2'b00, rng}) ? (OUT_W+1)'(r - {2'b00, rng}) : r[OUT_W:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr      <= SEED;
      st        <= IDLE;
      rnd_valid <= 1'b0;
      rnd_out   <= '0;
      dividend  <= '0;
      rem       <= '0;
      rng       <= '0;
      base_q    <= '0;
      cnt       <= '0;
    end else begin
      lfsr      <= (lfsr == '0) ? SEED : lfsr;
      rnd_valid <= 1'b0;
      if (seed_load) begin
        lfsr <= (seed_in != '0) ? seed_in : SEED;
        st   <= IDLE;
      end else begin
        case (st)
          IDLE: if (req) begin
            lfsr     <= nxt;
            dividend <= nxt;
            rng      <= range;
            base_q   <= base;
            rem      <= '0;
            cnt      <= CW'(WIDTH-1);
            st       <= DIV;
          end else if (free_run) lfsr <= nxt;
          DIV: begin
            rem <= rem_nxt;
            if (cnt == '0) begin
              st        <= DONE;
              rnd_valid <= 1'b1;
              rnd_out   <= rem_nxt[OUT_W-1:0] + base_q;
            end else cnt <= cnt - 1'b1;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lfsr_rand_ranged.sv
// tb_lfsr_rand_ranged: directed checks of an 8-bit legacy-polynomial instance and a default 16-bit instance.
module tb_lfsr_rand_ranged;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       seed_load = 1'b0, free_run = 1'b0, req = 1'b0;
  logic [7:0] seed_in = '0, range = '0, base = '0;
  logic       rdy, rnd_valid;
  logic [7:0] rnd_out, lfsr_q;
  logic        seed_load2 = 1'b0, free_run2 = 1'b0, req2 = 1'b0;
  logic [15:0] seed_in2 = '0;
  logic [7:0]  range2 = '0, base2 = '0;
  logic        rdy2, rnd_valid2;
  logic [7:0]  rnd_out2;
  logic [15:0] lfsr_q2;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  lfsr_rand_ranged #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h6F), .OUT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .free_run(free_run),
    .req(req), .range(range), .base(base), .rdy(rdy), .rnd_valid(rnd_valid),
    .rnd_out(rnd_out), .lfsr_q(lfsr_q));
  lfsr_rand_ranged dut16 (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load2), .seed_in(seed_in2), .free_run(free_run2),
    .req(req2), .range(range2), .base(base2), .rdy(rdy2), .rnd_valid(rnd_valid2),
    .rnd_out(rnd_out2), .lfsr_q(lfsr_q2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic draw(input string tag, input logic [7:0] r, input logic [7:0] b,
                      input logic [7:0] exp_q, input logic [7:0] exp_out);
    int lat;
    req = 1'b1; range = r; base = b;
    tick();
    req = 1'b0;
    lat = 0;
    while (!rnd_valid && lat < 40) begin tick(); lat++; end
    check({tag, "_lat"}, lat, 8);
    check({tag, "_q"}, lfsr_q, exp_q);
    check({tag, "_out"}, rnd_out, exp_out);
    tick();
    check({tag, "_pulse"}, {rdy, rnd_valid}, 2'b10);
  endtask
  initial begin
    int first, zeros, lat, gap, seen;
    logic [7:0] hold;
    tick();
    check("rst_out", {rdy, rnd_valid, rnd_out}, {1'b1, 1'b0, 8'h00});
    check("rst_q", lfsr_q, 8'h6F);
    check("rst_q16", lfsr_q2, 16'h006F);
    rst_n = 1'b1;
    tick();
    draw("d1", 8'd70, 8'd1, 8'hDE, 8'd13);
    draw("d2", 8'd70, 8'd1, 8'hA1, 8'd22);
    draw("d3", 8'd70, 8'd1, 8'h5F, 8'd26);
    draw("nomod", 8'd0, 8'd0, 8'hBE, 8'hBE);
    draw("wrap", 8'd0, 8'hFF, 8'h61, 8'h60);
    seed_load = 1'b1; seed_in = 8'h00;
    tick();
    seed_load = 1'b0;
    check("seed0", lfsr_q, 8'h6F);
    seed_load = 1'b1; seed_in = 8'h33; req = 1'b1;
    tick();
    seed_load = 1'b0; req = 1'b0;
    check("seed_vs_req_q", lfsr_q, 8'h33);
    check("seed_vs_req_rdy", rdy, 1'b1);
    req = 1'b1; range = 8'd70; base = 8'd1;
    tick();
    req = 1'b0;
    check("abort_busy", {rdy, lfsr_q}, {1'b0, 8'h66});
    tick();
    seed_load = 1'b1; seed_in = 8'h01;
    tick();
    seed_load = 1'b0;
    check("abort_q", lfsr_q, 8'h01);
    check("abort_rdy", rdy, 1'b1);
    check("abort_held", rnd_out, 8'h60);
    seen = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (rnd_valid) seen++; end
    check("abort_novalid", seen, 0);
    free_run = 1'b1;
    first = 0; zeros = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (lfsr_q == 8'h00) zeros++;
      if (lfsr_q == 8'h01 && first == 0) first = i;
    end
    check("period", first, 255);
    check("never0", zeros, 0);
    req = 1'b1; range = 8'd10; base = 8'd0;
    tick();
    req = 1'b0;
    hold = lfsr_q;
    check("fr_step", hold, 8'h02);
    for (int i = 0; i < 4; i++) tick();
    check("fr_held", lfsr_q, hold);
    lat = 0;
    while (!rnd_valid && lat < 20) begin tick(); lat++; end
    check("fr_out", rnd_out, 8'd2);
    free_run = 1'b0;
    req2 = 1'b1; range2 = 8'd100; base2 = 8'd0;
    lat = 0;
    while (!rnd_valid2 && lat < 60) begin tick(); lat++; end
    check("w16_lat", lat, 17);
    check("w16_out1", rnd_out2, 8'd22);
    gap = 0;
    do begin tick(); gap++; end while (!rnd_valid2 && gap < 60);
    check("w16_gap", gap, 18);
    check("w16_out2", rnd_out2, 8'd44);
    check("w16_q2", lfsr_q2, 16'h01BC);
    tick(); tick(); tick();
    check("w16_busy", rdy2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst16", {rdy2, rnd_valid2, rnd_out2, lfsr_q2}, {1'b1, 1'b0, 8'h00, 16'h006F});
    check("arst8", {rdy, rnd_valid, rnd_out, lfsr_q}, {1'b1, 1'b0, 8'h00, 8'h6F});
    req2 = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
